// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: streams W = cos - j*sin for every butterfly of
// every stage of an iterative radix-2 DIT FFT, over a val/rdy stream.
module fft_twiddle_sequencer #(
    parameter int BIT_WIDTH     = 32,
    parameter int DECIMAL_POINT = 16,
    parameter int SIZE_FFT      = 16,
    parameter int STAGE_FFT     = $clog2(SIZE_FFT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [BIT_WIDTH-1:0]       sine_wave_in [0:SIZE_FFT-1],
    input  logic                              start_val,
    output logic                              start_rdy,
    output logic                              send_val,
    input  logic                              send_rdy,
    output logic signed [BIT_WIDTH-1:0]       twiddle_real,
    output logic signed [BIT_WIDTH-1:0]       twiddle_imaginary,
    output logic [$clog2(STAGE_FFT)-1:0]      stage_idx,
    output logic [$clog2(SIZE_FFT/2)-1:0]     bfly_idx,
    output logic                              last
);
    localparam int SW = $clog2(STAGE_FFT);
    localparam int KW = $clog2(SIZE_FFT/2);
    localparam int IW = STAGE_FFT;
    localparam logic [SW-1:0] S_LAST  = SW'(STAGE_FFT - 1);
    localparam logic [KW-1:0] K_LAST  = '1;
    localparam logic [IW-1:0] QUARTER = IW'(SIZE_FFT / 4);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    r_state;
    logic                      r_start_rdy;
    logic                      r_send_val;
    logic signed [BIT_WIDTH-1:0] r_re;
    logic signed [BIT_WIDTH-1:0] r_im;
    logic [SW-1:0]             r_s;
    logic [KW-1:0]             r_k;
    logic                      r_last;

    logic                      w_load;
    logic                      w_adv;
    logic [SW-1:0]             w_ns;
    logic [KW-1:0]             w_nk;
    logic [IW-1:0]             w_mask;
    logic [IW-1:0]             w_j;
    logic [SW-1:0]             w_shamt;
    logic [IW-1:0]             w_idx;
    logic [IW-1:0]             w_cidx;

    assign w_load = (r_state == IDLE) && start_val;
    assign w_adv  = (r_state == RUN) && send_rdy && !r_last;

    // Coordinates of the beat about to be loaded: (0,0) on start, else next.
    always_comb begin
        w_ns = r_s;
        w_nk = r_k + KW'(1);
        if (w_load) begin
            w_ns = '0;
            w_nk = '0;
        end else if (r_k == K_LAST) begin
            w_ns = r_s + SW'(1);
        end
        w_mask  = (IW'(1) << w_ns) - IW'(1);
        w_j     = IW'(w_nk) & w_mask;
        w_shamt = S_LAST - w_ns;
        w_idx   = w_j << w_shamt;
        w_cidx  = w_idx + QUARTER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_start_rdy <= 1'b1;
            r_send_val  <= 1'b0;
            r_re        <= '0;
            r_im        <= '0;
            r_s         <= '0;
            r_k         <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_val) begin
                        r_state     <= RUN;
                        r_start_rdy <= 1'b0;
                        r_send_val  <= 1'b1;
                    end
                end
                RUN: begin
                    if (send_rdy && r_last) begin
                        r_state     <= IDLE;
                        r_start_rdy <= 1'b1;
                        r_send_val  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Data fields only move on load/advance, so they hold while stalled or idle.
            if (w_load || w_adv) begin
                r_s    <= w_ns;
                r_k    <= w_nk;
                r_re   <= sine_wave_in[w_cidx];
                r_im   <= -sine_wave_in[w_idx];
                r_last <= (w_ns == S_LAST) && (w_nk == K_LAST);
            end
        end
    end

    assign start_rdy         = r_start_rdy;
    assign send_val          = r_send_val;
    assign twiddle_real      = r_re;
    assign twiddle_imaginary = r_im;
    assign stage_idx         = r_s;
    assign bfly_idx          = r_k;
    assign last              = r_last;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Scoreboard bench for fft_twiddle_sequencer: a reference model pushes the
// expected beats on each accepted start; a negedge monitor compares them.
module tb_fft_twiddle_sequencer;
    localparam int BW   = 32;
    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int SW   = 2;
    localparam int KW   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_val = 1'b0;
    logic send_rdy = 1'b0;
    logic start_rdy, send_val, last;
    logic signed [BW-1:0] sine [0:N-1];
    logic signed [BW-1:0] tw_re, tw_im;
    logic [SW-1:0] stage_idx;
    logic [KW-1:0] bfly_idx;

    typedef struct {
        int s;
        int k;
        int re;
        int im;
        bit lst;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad = 0;
    int n_acc = 0;
    int n_seq = 0;
    int cyc = 0;
    int last_acc_cyc = -100;
    bit armed = 0;
    bit b2b = 0;
    bit rdy_rand = 0;
    bit rdy_hold = 0;

    fft_twiddle_sequencer #(
        .BIT_WIDTH(BW), .DECIMAL_POINT(16), .SIZE_FFT(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sine_wave_in(sine),
        .start_val(start_val),
        .start_rdy(start_rdy),
        .send_val(send_val),
        .send_rdy(send_rdy),
        .twiddle_real(tw_re),
        .twiddle_imaginary(tw_im),
        .stage_idx(stage_idx),
        .bfly_idx(bfly_idx),
        .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: beat (s,k) uses angle 2*pi*idx/N with idx = (k mod 2^s) * N/2^(s+1).
    task automatic push_seq();
        beat_t b;
        int idx;
        for (int s = 0; s < LOGN; s++) begin
            for (int k = 0; k < N/2; k++) begin
                idx   = (k % (1 << s)) * (N >> (s + 1));
                b.s   = s;
                b.k   = k;
                b.re  = int'(sine[(idx + N/4) % N]);
                b.im  = -int'(sine[idx]);
                b.lst = (s == LOGN - 1) && (k == N/2 - 1);
                q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (armed && !reset) begin
            chk("start_rdy_vs_send_val", int'(start_rdy), int'(!send_val));
            if (send_val) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got s=%0d k=%0d expected none",
                             stage_idx, bfly_idx);
                end else begin
                    e = q[0];
                    chk("stage_idx", int'(stage_idx), e.s);
                    chk("bfly_idx", int'(bfly_idx), e.k);
                    chk("twiddle_real", int'(tw_re), e.re);
                    chk("twiddle_imag", int'(tw_im), e.im);
                    chk("last", int'(last), int'(e.lst));
                    if (send_rdy) begin
                        void'(q.pop_front());
                        n_acc++;
                        if (e.lst) last_acc_cyc = cyc;
                        if (e.s == 0) begin
                            chk("s0_real", int'(tw_re), 65536);
                            chk("s0_imag", int'(tw_im), 0);
                        end
                        if (e.s == 1 && e.k == 1) begin
                            chk("s1k1_real", int'(tw_re), 0);
                            chk("s1k1_imag", int'(tw_im), -65536);
                        end
                        if (e.s == 3 && e.k == 1) begin
                            chk("s3k1_real", int'(tw_re), 60547);
                            chk("s3k1_imag", int'(tw_im), -25079);
                        end
                        if (e.s == 3 && e.k == 4) begin
                            chk("s3k4_real", int'(tw_re), 0);
                            chk("s3k4_imag", int'(tw_im), -65536);
                        end
                        if (e.s == 3 && e.k == 7) begin
                            chk("s3k7_real", int'(tw_re), -60547);
                            chk("s3k7_imag", int'(tw_im), -25079);
                        end
                    end
                end
            end
            if (start_val && start_rdy) begin
                if (b2b && last_acc_cyc >= 0)
                    chk("b2b_gap", cyc - last_acc_cyc, 1);
                push_seq();
                n_seq++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            send_rdy = rdy_rand ? 1'($urandom % 2) : rdy_hold;
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start_val = 1'b1;
        @(posedge clk);
        #1 start_val = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while ((q.size() != 0 || send_val) && i < bound);
        total++;
        if (q.size() != 0 || send_val) begin
            bad++;
            $display("FAIL %s_timeout: got pending=%0d send_val=%0d expected 0 0",
                     nm, q.size(), send_val);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_start_rdy"}, int'(start_rdy), 1);
        chk({nm, "_send_val"}, int'(send_val), 0);
        chk({nm, "_real"}, int'(tw_re), 0);
        chk({nm, "_imag"}, int'(tw_im), 0);
        chk({nm, "_stage"}, int'(stage_idx), 0);
        chk({nm, "_bfly"}, int'(bfly_idx), 0);
        chk({nm, "_last"}, int'(last), 0);
    endtask

    initial begin
        int n0;
        int i;
        for (int t = 0; t < N; t++)
            sine[t] = BW'($rtoi($sin(2.0 * 3.141592653589793 * t / N) * 65536.0));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");
        repeat (10) @(negedge clk);
        chk_idle_outputs("idle10");

        rdy_hold = 1'b1;
        n0 = n_acc;
        do_start();
        wait_idle(200, "unstalled");
        chk("unstalled_beats", n_acc - n0, 32);

        rdy_rand = 1'b1;
        n0 = n_acc;
        do_start();
        wait_idle(1000, "stalled");
        chk("stalled_beats", n_acc - n0, 32);
        rdy_rand = 1'b0;

        last_acc_cyc = -100;
        b2b = 1'b1;
        n0 = n_seq;
        i = n_acc;
        @(posedge clk);
        #1 start_val = 1'b1;
        for (int c = 0; c < 400 && n_seq < n0 + 2; c++) @(posedge clk);
        #1 start_val = 1'b0;
        chk("b2b_starts", n_seq - n0, 2);
        wait_idle(200, "b2b");
        chk("b2b_beats", n_acc - i, 64);
        b2b = 1'b0;

        n0 = n_acc;
        do_start();
        i = 0;
        while (n_acc - n0 < 13 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("midrun_reached", int'(n_acc - n0 >= 13), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrun_send_val", int'(send_val), 0);
        chk("midrun_start_rdy", int'(start_rdy), 1);
        chk("midrun_real", int'(tw_re), 0);

        n0 = n_acc;
        do_start();
        wait_idle(200, "restart");
        chk("restart_beats", n_acc - n0, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1);
    end
endmodule
